fixed_priority_dispatcher: RTL
==============================

# fixed_priority_dispatcher

Credit-based 1-to-N stream dispatcher: accepts one valid/ready input stream and forwards each beat to exactly one of `NumOut` output streams. The target is the lowest-index output that is enabled and holds a nonzero credit. It is the distribution-side counterpart of the fixed-priority N-to-1 arbiter and sits in front of replicated consumers: execution lanes, bank queues or DMA channels. Consumers return credits as they free buffer space.

## Interface
- `NumOut`, 4: number of output streams, ≥1.
- `DataWidth`, 8: beat width.
- `MaxCredit`, 2: per-output credit count at reset and saturation ceiling, ≥1; `CntW = $clog2(MaxCredit+1)`.
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `allow_i`  in  1  global accept enable; low blocks capture and does not block draining.
- `mask_i`  in  NumOut  per-output enable; bit i = 1 makes output i eligible.
- `in_data_i`  in  DataWidth  input beat.
- `in_valid_i`  in  1  input beat valid.
- `in_ready_o`  out  1  input accept.
- `out_data_o`  out  DataWidth  held beat, broadcast to all outputs.
- `out_valid_o`  out  NumOut  one-hot or zero; bit t means the beat is for output t.
- `out_ready_i`  in  NumOut  per-output accept.
- `credit_i`  in  NumOut  credit-return pulse, one credit per set bit per cycle.
- `credit_cnt_o`  out  NumOut*CntW  current credit counters, output i in bits [i*CntW +: CntW].
- `credit_err_o`  out  1  sticky: a credit was returned to a counter already at MaxCredit.

## Operation
- State:
  - single holding register: `full`, `data`, one-hot `tgt`;
  - per-output credit counters `cnt[i]`;
  - sticky `err`.
- `out_valid_o = full ? tgt : '0`. Valid depends only on registered state, never on `out_ready_i`.
- `drain = |(out_valid_o & out_ready_i)`.
- Eligible vector: `elig[i] = mask_i[i] & (cnt[i] != 0)`. Uses registered counts; same-cycle credit returns are not visible.
- `in_ready_o = rst_ni & allow_i & (|elig) & (~full | drain)`.
- Capture when `in_valid_i & in_ready_o`:
  - `data <= in_data_i`;
  - `tgt <=` lowest set bit of `elig`;
  - `full <= 1`.
- Drain without capture sets `full <= 0`. Drain with capture refills in the same cycle.
- Credit update per output i: `cnt[i] <= cnt[i] - dec[i] + inc[i]`.
  - `dec[i]` = captured beat targets i.
  - `inc[i] = credit_i[i]`.
  - Decrement and return in the same cycle net to no change.
  - A return at `cnt[i] == MaxCredit` with no same-cycle decrement saturates `cnt[i]` and sets `err`.
  - `cnt` never underflows: capture needs a nonzero count.
- A `mask_i` or `allow_i` change does not affect a held beat; it drains to its latched `tgt`.
- A held beat waits indefinitely for `out_ready_i[tgt]`. Readiness of other outputs is ignored: no re-steering, no reordering.
- Beats leave in acceptance order, one at a time.

## Timing
- Reset (rst_ni low at a rising edge):
  - `full = 0`, `out_valid_o = 0`, `out_data_o = 0`;
  - all `cnt = MaxCredit`;
  - `credit_err_o = 0`;
  - `in_ready_o` forced 0 while `rst_ni` is low.
- Reset mid-transfer: the held beat is dropped and credits are restored to MaxCredit.
- Latency: a beat captured at edge k shows `out_valid_o` in the cycle after edge k. It leaves at the first later edge where `out_ready_i[tgt]` is high.
- Throughput: 1 beat/cycle when the target sink is always ready and credits are available. `in_ready_o` is combinational from `out_ready_i`, through `drain`.
- A credit returned during cycle k is usable for capture at edge k+1 at the earliest.
- `credit_cnt_o` reflects registered counts and updates at the edge after the event.
- `credit_err_o` stays high until reset.

## Test plan
- **Reset values.** Hold `rst_ni = 0` for 2 cycles with `in_valid_i = 1`. Required: `in_ready_o = 0`, `out_valid_o = 0`, every `cnt = 2`, `credit_err_o = 0`. Release reset with `mask_i = 4'b1111`. Required: the first beat `0xA5` is captured at the next edge, and `out_valid_o = 4'b0001` one cycle later.
- **Priority with credit exhaustion.** All sinks ready, no credit returns, stream `0x01..0x08`. Required routing:
  - `0x01`, `0x02` to output 0;
  - `0x03`, `0x04` to output 1;
  - `0x05`, `0x06` to output 2;
  - `0x07`, `0x08` to output 3;
  - then `in_ready_o = 0`.
  - Returning one credit on output 2 allows exactly one more beat, routed to output 2.
- **Mask and stall.** Set `mask_i = 4'b0100` and hold `out_ready_i[2] = 0` for 5 cycles. Required: the beat is held on `out_valid_o = 4'b0100` with stable data. Set `mask_i = 4'b0001` mid-stall. Required: the held beat still drains to output 2, and the next beat goes to output 0.
- **Back-to-back refill.** `out_ready_i` all 1, credits returned every cycle. Required: 1 beat/cycle for 16 beats, with no bubbles and no data loss.
- **Simultaneous events and overflow.** Capture to output 0 in the same cycle as `credit_i[0] = 1` at `cnt[0] = 2`. Required: `cnt[0]` stays 2 and no error. Then a return on output 3 at `cnt[3] = 2` with no capture. Required: `cnt[3]` stays 2 and `credit_err_o` goes to 1 and stays 1.
- **Reset mid-operation.** Assert reset with a beat held and `cnt[1] = 0`. Required: `full = 0` and all `cnt = 2` after the edge.

Source files
------------

// File: rtl/fixed_priority_dispatcher.sv
// fixed_priority_dispatcher: credit-based 1-to-N stream dispatcher, one holding register,
// each beat goes to the lowest-index enabled output with a nonzero credit.
module fixed_priority_dispatcher #(
  parameter int NumOut    = 4,
  parameter int DataWidth = 8,
  parameter int MaxCredit = 2,
  localparam int CntW     = $clog2(MaxCredit + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   allow_i,
  input  logic [NumOut-1:0]      mask_i,
  input  logic [DataWidth-1:0]   in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [DataWidth-1:0]   out_data_o,
  output logic [NumOut-1:0]      out_valid_o,
  input  logic [NumOut-1:0]      out_ready_i,
  input  logic [NumOut-1:0]      credit_i,
  output logic [NumOut*CntW-1:0] credit_cnt_o,
  output logic                   credit_err_o
);
  logic                 r_full;
  logic [DataWidth-1:0] r_data;
  logic [NumOut-1:0]    r_tgt;
  logic [CntW-1:0]      r_cnt [NumOut];
  logic                 r_err;
  logic [NumOut-1:0]    w_elig, w_first, w_dec, w_at_max, w_ovf;
  logic                 w_drain, w_cap;
  for (genvar g = 0; g < NumOut; g++) begin : g_out
    assign w_elig[g]                    = mask_i[g] & (r_cnt[g] != '0);
    assign w_at_max[g]                  = r_cnt[g] == CntW'(MaxCredit);
    assign credit_cnt_o[g*CntW +: CntW] = r_cnt[g];
  end
  // isolate the lowest set bit of the eligible vector
  assign w_first      = w_elig & (~w_elig + NumOut'(1));
  assign out_valid_o  = r_full ? r_tgt : '0;
  assign out_data_o   = r_data;
  assign w_drain      = |(out_valid_o & out_ready_i);
  assign in_ready_o   = rst_ni & allow_i & (|w_elig) & (~r_full | w_drain);
  assign w_cap        = in_valid_i & in_ready_o;
  assign w_dec        = w_cap ? w_first : '0;
  assign w_ovf        = credit_i & ~w_dec & w_at_max;
  assign credit_err_o = r_err;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_tgt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_cap) begin
        r_full <= 1'b1;
        r_data <= in_data_i;
        r_tgt  <= w_first;
      end else if (w_drain) begin
        r_full <= 1'b0;
      end
      if (|w_ovf) r_err <= 1'b1;
    end
  end
  // a return and a consumption in the same cycle cancel; a return at the ceiling saturates
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumOut; i++) begin
      if (!rst_ni) r_cnt[i] <= CntW'(MaxCredit);
      else if (w_dec[i] && !credit_i[i]) r_cnt[i] <= r_cnt[i] - CntW'(1);
      else if (credit_i[i] && !w_dec[i] && !w_at_max[i]) r_cnt[i] <= r_cnt[i] + CntW'(1);
    end
  end
endmodule
